// File: rtl/rll27_stream_encoder_pkg.sv
// RLL(2,7) encoder shared definitions: FSM encodings, code table and the
// prefix-free source-word decoder used by the encoder top.
package rll27_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        FLUSH = ST_FLUSH
    } state_t;

    // Code words left-aligned in 8 bits, MSB emitted first
    localparam logic [7:0] CW_10   = 8'b0100_0000;
    localparam logic [7:0] CW_11   = 8'b1000_0000;
    localparam logic [7:0] CW_000  = 8'b0001_0000;
    localparam logic [7:0] CW_010  = 8'b1001_0000;
    localparam logic [7:0] CW_011  = 8'b0010_0000;
    localparam logic [7:0] CW_0010 = 8'b0010_0100;
    localparam logic [7:0] CW_0011 = 8'b0000_1000;

    localparam logic [3:0] CL_2 = 4'd4;
    localparam logic [3:0] CL_3 = 4'd6;
    localparam logic [3:0] CL_4 = 4'd8;
    localparam logic [2:0] SL_2 = 3'd2;
    localparam logic [2:0] SL_3 = 3'd3;
    localparam logic [2:0] SL_4 = 3'd4;

    typedef struct packed {
        logic [2:0] src_len;
        logic [7:0] code;
        logic [3:0] code_len;
    } word_t;

    function automatic logic [2:0] rll27_req_len(input logic [3:0] head);
        if (head[3])                 return SL_2;
        else if (head[2:1] == 2'b01) return SL_4;
        else                         return SL_3;
    endfunction

    function automatic word_t rll27_decode(input logic [3:0] head);
        word_t w;
        if (head[3]) begin
            w = '{SL_2, (head[2] ? CW_11 : CW_10), CL_2};
        end else begin
            case (head[2:1])
                2'b00:   w = '{SL_3, CW_000, CL_3};
                2'b10:   w = '{SL_3, CW_010, CL_3};
                2'b11:   w = '{SL_3, CW_011, CL_3};
                default: w = '{SL_4, (head[0] ? CW_0011 : CW_0010), CL_4};
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/rll27_stream_encoder_if.sv
// Handshake bundle of the RLL(2,7) encoder: serial data in, code bits out.
interface rll27_stream_encoder_if #(
    parameter int OUT_W = 8
) ();
    logic             data_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic             flush_i;
    logic             code_o;
    logic             code_valid_o;
    logic             code_ready_i;
    logic [OUT_W-1:0] data_o;
    logic             busy_o;

    modport master (
        output data_i, data_valid_i, flush_i, code_ready_i,
        input  data_ready_o, code_o, code_valid_o, data_o, busy_o
    );

    modport slave (
        input  data_i, data_valid_i, flush_i, code_ready_i,
        output data_ready_o, code_o, code_valid_o, data_o, busy_o
    );
endinterface

// File: rtl/rll27_stream_encoder_fifo.sv
// 1-bit wide FIFO with a 4-bit head peek window and a 0..4 bit pop per cycle.
module rll_bit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     push_i,
    input  logic                     data_i,
    input  logic [2:0]               pop_len_i,
    output logic [3:0]               peek_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    always_comb begin
        peek_o = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            peek_o[3-i] = mem_q[rd_ptr_q + AW'(i)];
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            rd_ptr_q <= rd_ptr_q + AW'(pop_len_i);
            count_q  <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_len_i);
        end
    end
endmodule

// File: rtl/rll27_stream_encoder.sv
// RLL(2,7) rate-1/2 stream encoder: bit FIFO, word parser, code serialiser.
// Define RLL27_NRZI_EN to NRZI-precode code_o and the data_o history.
module rll27_stream_encoder
    import rll27_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OUT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    rll27_stream_encoder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [3:0]       bits_q, bits_d;
    logic             flush_q, flush_d;
    logic [OUT_W-1:0] hist_q, hist_d;

    logic [3:0]    peek, head;
    logic [CW-1:0] fifo_cnt, cnt_next;
    logic          fifo_full, data_ready, push, shifting, accept, last;
    logic          dec_ok, pad_ok, load, out_bit;
    logic [2:0]    pop_len;
    word_t         word;

    rll_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .arst_i    (arst_i),
        .push_i    (push),
        .data_i    (bus.data_i),
        .pop_len_i (pop_len),
        .peek_o    (peek),
        .count_o   (fifo_cnt),
        .full_o    (fifo_full)
    );

`ifdef RLL27_NRZI_EN
    logic level_q;
    assign out_bit = level_q ^ sr_q[7];
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i)     level_q <= 1'b0;
        else if (accept) level_q <= out_bit;
    end
`else
    assign out_bit = sr_q[7];
`endif

    assign data_ready = arst_i && !fifo_full && !flush_q;
    assign push       = bus.data_valid_i && data_ready;
    assign shifting   = (state_q == SHIFT);
    assign accept     = shifting && bus.code_ready_i;
    assign last       = accept && (bits_q == 4'd1);

    always_comb begin
        // Bits beyond the FIFO count are zeroed so a flushed tail decodes as its padded word
        head = peek;
        if (fifo_cnt < CW'(4)) head[0] = 1'b0;
        if (fifo_cnt < CW'(3)) head[1] = 1'b0;
        if (fifo_cnt < CW'(2)) head[2] = 1'b0;
        dec_ok = (fifo_cnt != '0) && (fifo_cnt >= CW'(rll27_req_len(peek)));
        pad_ok = flush_q && (fifo_cnt != '0) && !dec_ok;
        word   = rll27_decode(head);
        load   = (!shifting || last) && (dec_ok || pad_ok);

        pop_len = 3'd0;
        if (load) pop_len = dec_ok ? word.src_len : 3'(fifo_cnt);
        cnt_next = fifo_cnt + CW'(push) - CW'(pop_len);

        sr_d   = sr_q;
        bits_d = bits_q;
        if (load) begin
            sr_d   = word.code;
            bits_d = word.code_len;
        end else if (accept) begin
            sr_d   = {sr_q[6:0], 1'b0};
            bits_d = bits_q - 4'd1;
        end

        flush_d = (flush_q || (bus.flush_i && ((fifo_cnt != '0) || push)))
                  && (cnt_next != '0);

        if (load || (shifting && !last)) state_d = SHIFT;
        else if (flush_d)                state_d = FLUSH;
        else                             state_d = IDLE;

        hist_d = accept ? {hist_q[OUT_W-2:0], out_bit} : hist_q;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bits_q  <= '0;
            flush_q <= 1'b0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bits_q  <= bits_d;
            flush_q <= flush_d;
            hist_q  <= hist_d;
        end
    end

    assign bus.data_ready_o = data_ready;
    assign bus.code_o       = shifting && out_bit;
    assign bus.code_valid_o = shifting;
    assign bus.data_o       = hist_q;
    assign bus.busy_o       = (fifo_cnt != '0) || shifting || flush_q;
endmodule

// File: tb/tb_rll27_stream_encoder.sv
// Directed self-checking bench for rll27_stream_encoder (DEPTH=8, OUT_W=8).
module tb_rll27_stream_encoder;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic bits_q[$];

    always #5 clk = ~clk;

    rll27_stream_encoder_if #(.OUT_W(8)) bus ();

    rll27_stream_encoder #(.DEPTH(8), .OUT_W(8)) dut (
        .clk_i  (clk),
        .arst_i (arst_n),
        .bus    (bus)
    );

    // Accepted code bits are recorded half a cycle before the accepting edge
    always @(negedge clk) begin
        cyc++;
        if (arst_n && bus.code_valid_o && bus.code_ready_i) bits_q.push_back(bus.code_o);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_bit(input logic b);
        int n = 0;
        bus.data_i = b;
        bus.data_valid_i = 1'b1;
        while (!bus.data_ready_o && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
        tick(1);
        bus.data_valid_i = 1'b0;
    endtask

    task automatic wait_bits(input int n, input string tag);
        int k = 0;
        while (bits_q.size() < n && k < 500) begin
            tick(1);
            k++;
        end
        if (k >= 500) chk(tag, 32'(bits_q.size()), 32'(n));
    endtask

    task automatic take(input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            if (bits_q.size() > 0) v = {v[30:0], bits_q.pop_front()};
            else                   v = {v[30:0], 1'bx};
        end
    endtask

    initial begin
        logic [31:0] v;
        logic        held;
        int          acc;
        int          k;
        bus.data_i = 1'b0;
        bus.data_valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.code_ready_i = 1'b1;

        // Reset state
        tick(2);
        chk("rst_valid", 32'(bus.code_valid_o), 32'd0);
        chk("rst_code",  32'(bus.code_o), 32'd0);
        chk("rst_data",  32'(bus.data_o), 32'd0);
        chk("rst_busy",  32'(bus.busy_o), 32'd0);
        chk("rst_ready", 32'(bus.data_ready_o), 32'd0);
        arst_n = 1'b1;
        tick(1);

        // 10 -> 0100
        push_bit(1'b1);
        push_bit(1'b0);
        wait_bits(4, "t1_timeout");
        take(4, v);
`ifdef RLL27_NRZI_EN
        chk("t1_code", v, 32'b0111);
        chk("t1_hist", 32'(bus.data_o), 32'h07);
`else
        chk("t1_code", v, 32'b0100);
        chk("t1_hist", 32'(bus.data_o), 32'h04);
`endif
        k = 0;
        while (bus.busy_o && k < 20) begin tick(1); k++; end
        chk("t1_busy", 32'(bus.busy_o), 32'd0);

`ifndef RLL27_NRZI_EN
        // 0011 + 010 -> 00001000 100100, gap-free across the word boundary
        begin
            int c0;
            int cstart;
            cstart = cyc;
            push_bit(0); push_bit(0); push_bit(1); push_bit(1);
            push_bit(0); push_bit(1); push_bit(0);
            wait_bits(14, "t2_timeout");
            c0 = cyc;
            take(14, v);
            chk("t2_code", v, 32'b00001000_100100);
            chk("t2_hist", 32'(bus.data_o), 32'h24);
            // 14 bits back-to-back means no more than 14 accepting cycles elapsed past the first
            chk("t2_window", 32'(c0 - cstart <= 14 + 8), 32'd1);
        end

        // 11 with output stalled: 1 held, then 1000
        bus.code_ready_i = 1'b0;
        push_bit(1); push_bit(1);
        k = 0;
        while (!bus.code_valid_o && k < 20) begin tick(1); k++; end
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            held = held & bus.code_valid_o & bus.code_o;
            tick(1);
        end
        chk("t3_held", 32'(held), 32'd1);
        chk("t3_none", 32'(bits_q.size()), 32'd0);
        bus.code_ready_i = 1'b1;
        wait_bits(4, "t3_timeout");
        take(4, v);
        chk("t3_code", v, 32'b1000);

        // 12 ones with output stalled: FIFO fills, then 6x 1000
        bus.code_ready_i = 1'b0;
        bus.data_i = 1'b1;
        bus.data_valid_i = 1'b1;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.data_ready_o) acc++;
            tick(1);
        end
        bus.data_valid_i = 1'b0;
        chk("t4_accepted", 32'(acc), 32'd10);
        chk("t4_ready", 32'(bus.data_ready_o), 32'd0);
        chk("t4_busy", 32'(bus.busy_o), 32'd1);
        bus.code_ready_i = 1'b1;
        push_bit(1); push_bit(1);
        wait_bits(24, "t4_timeout");
        tick(10);
        chk("t4_count", 32'(bits_q.size()), 32'd24);
        for (int w = 0; w < 6; w++) begin
            take(4, v);
            chk($sformatf("t4_word%0d", w), v, 32'b1000);
        end

        // 001 + flush -> 0010 -> 00100100
        push_bit(0); push_bit(0); push_bit(1);
        bus.flush_i = 1'b1;
        tick(1);
        bus.flush_i = 1'b0;
        chk("t5_ready_low", 32'(bus.data_ready_o), 32'd0);
        wait_bits(8, "t5_timeout");
        take(8, v);
        chk("t5_code", v, 32'b00100100);
        chk("t5_ready_back", 32'(bus.data_ready_o), 32'd1);
`endif

        // Reset after two bits of 000100, then 11 -> 1000 only
        bits_q.delete();
        push_bit(0); push_bit(0); push_bit(0);
        k = 0;
        while (bits_q.size() < 2 && k < 50) begin tick(1); k++; end
        arst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.code_valid_o), 32'd0);
        chk("t6_code",  32'(bus.code_o), 32'd0);
        chk("t6_data",  32'(bus.data_o), 32'd0);
        chk("t6_busy",  32'(bus.busy_o), 32'd0);
        chk("t6_ready", 32'(bus.data_ready_o), 32'd0);
        tick(2);
        arst_n = 1'b1;
        tick(1);
        bits_q.delete();
        push_bit(1); push_bit(1);
        wait_bits(4, "t6_timeout");
        tick(10);
        chk("t6_count", 32'(bits_q.size()), 32'd4);
        take(4, v);
`ifdef RLL27_NRZI_EN
        chk("t6_after", v, 32'b1111);
`else
        chk("t6_after", v, 32'b1000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
